spi_reg_slave: RTL and testbench
================================

# spi_reg_slave

SPI responder with a byte-oriented command protocol fronting a 16 x 8 register file. It is the target-side counterpart to `spi_master`: the master issues a command byte, then streams write data into, or read data out of, consecutive registers. The block runs entirely on the system clock, oversampling `SPI_SCLK`, `CS` and `MOSI`. User logic gets a local read/write port and a per-byte write strobe.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth on `SPI_SCLK`, `CS` and `MOSI`; legal values 2 or 3.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `SPI_SCLK` in 1: serial clock from the master.
- `CS` in 1: chip select, active low.
- `MOSI` in 1: serial data in, MSB first.
- `MISO` out 1: serial data out, MSB first; 0 while `CS` is high.
- `CPOL` in 1: clock polarity; static while `CS` is low.
- `CPHA` in 1: clock phase; static while `CS` is low.
- `busy` out 1: registered copy of the synchronized `!CS`.
- `loc_addr` in 4: local port address.
- `loc_rdata` out 8: combinational read of `reg[loc_addr]`.
- `loc_we` in 1: local write enable.
- `loc_wdata` in 8: local write data.
- `wr_pulse` out 1: one-cycle strobe on each completed SPI write byte.
- `wr_addr` out 4: register address for the current `wr_pulse`.
- `wr_data` out 8: data for the current `wr_pulse`.

## Operation
- **Edge definitions.** Leading edge is `SPI_SCLK` 0->1 if `CPOL`=0, else 1->0. Sample edge is the leading edge when `CPHA`=0, the trailing edge otherwise. Shift edge is the other edge.
- **Command byte**, first byte after `CS` falls:
  - bit7: 1 = read, 0 = write.
  - bits6:4: reserved, must be 000.
  - bits3:0: start address.
- **States:**
  - IDLE -> CMD on `CS` falling.
  - CMD -> WR or RD after the 8th sample, according to bit7.
  - CMD -> IGNORE when the reserved bits are nonzero.
  - Any state -> IDLE when `CS` rises.
- **Bit counter** `bitcnt` (3 bits) counts samples within the current byte; it wraps 7->0 on byte completion and clears on `CS` falling.
- **WR.** Each completed byte is written to `reg[addr]`; `wr_pulse`, `wr_addr` and `wr_data` are asserted; then `addr` increments.
- **RD.** On completion of the command byte, and of each later byte, `tx_byte` loads `reg[addr]` and `addr` increments.
- **Address wrap:** `addr` wraps 15->0 in both WR and RD.
- **MISO.** `MISO` register <= `tx_byte[7-bitcnt]` on each shift edge.
  - When `CPHA`=0 it is also loaded on `CS` falling.
  - `tx_byte` is 0x00 during CMD and in IGNORE.
- **Partial byte.** A partial byte at `CS` rise is discarded: no write, no strobe.
- **Simultaneous writes.** When an SPI write and `loc_we` hit the same address in the same cycle, the SPI write wins. Different addresses are both written.
- **Reset**, including mid-transfer:
  - All registers, `addr`, `bitcnt` and `tx_byte` go to 0; state goes to IDLE.
  - `MISO`=0, `busy`=0, `wr_pulse`=0, `wr_addr`=0, `wr_data`=0.
  - After reset release, a transfer already in progress is ignored until `CS` goes high.

## Timing
- **Input latency.** `SYNC_STAGES` cycles from pin to synchronized signal, plus 1 cycle for edge detection.
- **Clock limits.** `SPI_SCLK` frequency must be <= clk/8. Each `SPI_SCLK` high and low phase must be >= 4 clk.
- **Write latency.** `wr_pulse` is asserted 1 cycle after the internal sample of bit 0. The register file updates in that same cycle.
- **Read preload.** `tx_byte` loads in the same cycle as the byte-completion sample. This guarantees the next MSB is valid at the next shift edge.
- **CS setup.** `CS` falling must precede the first `SPI_SCLK` edge by >= `SYNC_STAGES`+2 clk.
- **MISO timing.** `MISO` changes `SYNC_STAGES`+2 clk after the pin-level shift edge. The master samples half an SCLK period later.
- **Local port.** `loc_rdata` is combinational. Local writes take effect on the next clk edge.

## Structure
- **Shared package `spi_defs`.** Holds:
  - state encoding (IDLE, CMD, WR, RD, IGNORE);
  - command bit positions (`RW_BIT`=7, `RSV_MSB`=6, `RSV_LSB`=4, `ADDR_W`=4);
  - `DATA_W`=8.
- **Sub-module `spi_sync_edge`.** One per input pin: an N-stage synchronizer plus rise/fall pulse outputs.
- **Top level** holds the FSM, the bit counter, the shift registers and the register file.

## Test plan
- **Mode 0 write.** Send 0x03, 0xAA, 0x55 -> `reg3`=0xAA and `reg4`=0x55. Two `wr_pulse` strobes: (3,0xAA) then (4,0x55).
- **Read in all four modes.** Preload `reg15`=0xC3 and `reg0`=0x3C via the local port. Send 0x8F, 0x00, 0x00 -> `MISO` returns 0x00, 0xC3, 0x3C (address wraps 15->0).
- **Reserved bits.** Send 0x13, 0x77 -> no write, no `wr_pulse`, `MISO` stays 0.
- **Partial byte.** Send 0x02, then 5 bits of 0xFF, then raise `CS` -> `reg2` is unchanged and there is no strobe. The next transfer works normally.
- **Write collision.** Make `loc_we` to address 5 coincide with the SPI write of 0x11 to address 5 -> `reg5`=0x11.
- **Reset mid-transfer.** Assert `rst` during an RD byte -> `MISO`=0, `busy`=0, all registers 0x00. The transfer resumes only after `CS` goes high, then low again.

Source files
------------

// File: rtl/spi_defs.sv
// Shared definitions for the SPI register slave: FSM states, command-byte layout and widths.
package spi_defs;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned RW_BIT   = 7;
  localparam int unsigned RSV_MSB  = 6;
  localparam int unsigned RSV_LSB  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WR,
    ST_RD,
    ST_IGNORE
  } state_e;

  // One completed SPI write, as presented on the strobe port
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_beat_t;

  function automatic logic cmd_rsv_ok(input logic [DATA_W-1:0] cmd);
    return cmd[RSV_MSB:RSV_LSB] == '0;
  endfunction

endpackage

// File: rtl/spi_reg_slave_if.sv
// Pin-level SPI bus plus local register port of the SPI register slave.
interface spi_reg_slave_if;
  import spi_defs::*;

  logic              SPI_SCLK;
  logic              CS;
  logic              MOSI;
  logic              MISO;
  logic              CPOL;
  logic              CPHA;
  logic              busy;
  logic [ADDR_W-1:0] loc_addr;
  logic [DATA_W-1:0] loc_rdata;
  logic              loc_we;
  logic [DATA_W-1:0] loc_wdata;
  logic              wr_pulse;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport slave (
    input  SPI_SCLK, CS, MOSI, CPOL, CPHA, loc_addr, loc_we, loc_wdata,
    output MISO, busy, loc_rdata, wr_pulse, wr_addr, wr_data
  );

  modport master (
    output SPI_SCLK, CS, MOSI, CPOL, CPHA, loc_addr, loc_we, loc_wdata,
    input  MISO, busy, loc_rdata, wr_pulse, wr_addr, wr_data
  );

endinterface

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer for one asynchronous pin, with rise/fall pulses of the synchronized level.
module spi_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q,
  output logic o_rise_c,
  output logic o_fall_c
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // Chain resets to 0 so a low pin at reset release never produces a falling pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_q      = r_sync[STAGES-1];
  assign o_rise_c = r_sync[STAGES-1] & ~r_prev;
  assign o_fall_c = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI responder with a command byte protocol in front of a 16 x 8 register file,
// fully clocked by clk with oversampled SPI pins.
module spi_reg_slave
  import spi_defs::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic            clk,
  input logic            rst,
  spi_reg_slave_if.slave bus
);

  logic w_sclk, w_sclk_rise, w_sclk_fall;
  logic w_cs, w_cs_rise, w_cs_fall;
  logic w_mosi, w_mosi_rise, w_mosi_fall;
  logic w_unused_edges;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst(rst), .i_d(bus.SPI_SCLK),
    .o_q(w_sclk), .o_rise_c(w_sclk_rise), .o_fall_c(w_sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst(rst), .i_d(bus.CS),
    .o_q(w_cs), .o_rise_c(w_cs_rise), .o_fall_c(w_cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst(rst), .i_d(bus.MOSI),
    .o_q(w_mosi), .o_rise_c(w_mosi_rise), .o_fall_c(w_mosi_fall)
  );

  assign w_unused_edges = ^{w_sclk, w_cs_rise, w_mosi_rise, w_mosi_fall};

  state_e            r_state, w_state_next;
  logic [DATA_W-2:0] r_shift;
  logic [2:0]        r_bitcnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_tx;
  logic              r_miso;
  logic              r_busy;
  logic              r_armed;
  logic              r_wr_pulse;
  wr_beat_t          r_wr_beat;
  logic [DATA_W-1:0] r_regs [NUM_REGS];

  logic              w_lead, w_trail, w_active, w_samp_act, w_shift_act;
  logic              w_byte_done;
  logic [DATA_W-1:0] w_byte;
  logic [ADDR_W-1:0] w_addr_base;
  logic              w_spi_we, w_tx_load, w_addr_load, w_addr_inc;

  // Map the SPI mode onto sample/shift pulses of the synchronized clock
  assign w_lead      = bus.CPOL ? w_sclk_fall : w_sclk_rise;
  assign w_trail     = bus.CPOL ? w_sclk_rise : w_sclk_fall;
  assign w_active    = (r_state != ST_IDLE) && !w_cs;
  assign w_samp_act  = w_active && (bus.CPHA ? w_trail : w_lead);
  assign w_shift_act = w_active && (bus.CPHA ? w_lead : w_trail);
  assign w_byte      = {r_shift, w_mosi};
  assign w_byte_done = w_samp_act && (r_bitcnt == 3'd7);
  assign w_addr_base = (r_state == ST_CMD) ? w_byte[ADDR_W-1:0] : r_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_spi_we     = 1'b0;
    w_tx_load    = 1'b0;
    w_addr_load  = 1'b0;
    w_addr_inc   = 1'b0;
    unique case (r_state)
      ST_IDLE: if (w_cs_fall) w_state_next = ST_CMD;
      ST_CMD: begin
        if (w_byte_done) begin
          w_addr_load = 1'b1;
          if (!cmd_rsv_ok(w_byte)) begin
            w_state_next = ST_IGNORE;
          end else if (w_byte[RW_BIT]) begin
            w_state_next = ST_RD;
            w_tx_load    = 1'b1;
          end else begin
            w_state_next = ST_WR;
          end
        end
      end
      ST_WR: begin
        if (w_byte_done) begin
          w_spi_we   = 1'b1;
          w_addr_inc = 1'b1;
        end
      end
      ST_RD: begin
        if (w_byte_done) begin
          w_tx_load  = 1'b1;
          w_addr_inc = 1'b1;
        end
      end
      ST_IGNORE: ;
      default: w_state_next = ST_IDLE;
    endcase
    if (w_cs) w_state_next = ST_IDLE;
  end

  // Shift/count/address datapath; a read preload and the address step share the completion cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift    <= '0;
      r_bitcnt   <= '0;
      r_addr     <= '0;
      r_tx       <= '0;
      r_miso     <= 1'b0;
      r_busy     <= 1'b0;
      r_armed    <= 1'b0;
      r_wr_pulse <= 1'b0;
      r_wr_beat  <= '0;
    end else begin
      r_armed    <= r_armed | w_cs;
      r_busy     <= r_armed & ~w_cs;
      r_wr_pulse <= w_spi_we;
      if (w_spi_we) r_wr_beat <= '{addr: r_addr, data: w_byte};

      if (w_cs_fall) begin
        r_bitcnt <= '0;
      end else if (w_samp_act) begin
        r_shift  <= w_byte[DATA_W-2:0];
        r_bitcnt <= r_bitcnt + 3'd1;
      end

      if (w_cs_fall)      r_tx <= '0;
      else if (w_tx_load) r_tx <= r_regs[w_addr_base];

      if (w_addr_load || w_addr_inc)
        r_addr <= w_addr_base + ADDR_W'(w_tx_load | w_spi_we);

      // tx_byte is cleared at CS fall, so the CPHA=0 first-bit preload is a 0
      if (w_cs || w_cs_fall) r_miso <= 1'b0;
      else if (w_shift_act)  r_miso <= r_tx[3'd7 - r_bitcnt];
    end
  end

  // SPI write is issued after the local write so it wins on an address collision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_regs <= '{default: '0};
    end else begin
      if (bus.loc_we) r_regs[bus.loc_addr] <= bus.loc_wdata;
      if (w_spi_we)   r_regs[r_addr]       <= w_byte;
    end
  end

  assign bus.MISO      = r_miso;
  assign bus.busy      = r_busy;
  assign bus.loc_rdata = r_regs[bus.loc_addr];
  assign bus.wr_pulse  = r_wr_pulse;
  assign bus.wr_addr   = r_wr_beat.addr;
  assign bus.wr_data   = r_wr_beat.data;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Bench for spi_reg_slave: bit-banged SPI master in all four modes against a register-array model.
module tb_spi_reg_slave;

  localparam int HALF = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_reg_slave_if bus ();
  spi_reg_slave #(.SYNC_STAGES(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  int          n_pass   = 0;
  int          n_checks = 0;
  logic [7:0]  m_regs [16];
  logic [11:0] exp_q [$];
  logic [11:0] obs_q [$];
  logic [7:0]  tx_buf [8];
  logic [7:0]  rx_buf [8];
  logic [7:0]  exp_rx [8];

  always @(negedge clk) if (!rst && bus.wr_pulse) obs_q.push_back({bus.wr_addr, bus.wr_data});

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout req completion");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_mode(input int m);
    tick(1);
    bus.CPOL = m[1]; bus.CPHA = m[0]; bus.SPI_SCLK = m[1];
    tick(8);
  endtask

  task automatic cs_low();
    tick(2); bus.CS = 1'b0; tick(8);
  endtask

  task automatic cs_high();
    tick(HALF); bus.CS = 1'b1; tick(12);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!bus.CPHA) begin
        bus.MOSI = tx[i]; tick(HALF);
        bus.SPI_SCLK = ~bus.CPOL; rx[i] = bus.MISO; tick(HALF);
        bus.SPI_SCLK = bus.CPOL;
      end else begin
        tick(HALF);
        bus.SPI_SCLK = ~bus.CPOL; bus.MOSI = tx[i]; tick(HALF);
        bus.SPI_SCLK = bus.CPOL; rx[i] = bus.MISO;
      end
    end
  endtask

  task automatic run_xfer(input int n);
    logic [7:0] rx;
    cs_low();
    for (int k = 0; k < n; k++) begin
      spi_bits(tx_buf[k], 8, rx);
      rx_buf[k] = rx;
    end
    cs_high();
  endtask

  task automatic loc_write(input logic [3:0] a, input logic [7:0] d);
    bus.loc_addr = a; bus.loc_wdata = d; bus.loc_we = 1'b1;
    tick(1);
    bus.loc_we = 1'b0;
    m_regs[a] = d;
  endtask

  task automatic loc_read(input logic [3:0] a, output logic [7:0] d);
    bus.loc_addr = a;
    #1;
    d = bus.loc_rdata;
  endtask

  // Reference: command byte decides; reads return consecutive registers, writes fill them
  task automatic model_xfer(input int n);
    logic [3:0] a;
    a = tx_buf[0][3:0];
    exp_rx[0] = 8'h00;
    for (int k = 1; k < n; k++) begin
      exp_rx[k] = 8'h00;
      if (tx_buf[0][6:4] == 3'b000) begin
        if (tx_buf[0][7]) begin
          exp_rx[k] = m_regs[a];
        end else begin
          m_regs[a] = tx_buf[k];
          exp_q.push_back({a, tx_buf[k]});
        end
        a = a + 4'd1;
      end
    end
  endtask

  task automatic clear_q();
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    logic [7:0] d;
    tick(3);
    n_checks++; if (bus.MISO !== 1'b0) $display("FAIL reset_miso got %b req 0", bus.MISO); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b req 0", bus.busy); else n_pass++;
    n_checks++; if (bus.wr_pulse !== 1'b0) $display("FAIL reset_wr_pulse got %b req 0", bus.wr_pulse); else n_pass++;
    n_checks++; if (bus.wr_addr !== 4'h0) $display("FAIL reset_wr_addr got %h req 0", bus.wr_addr); else n_pass++;
    n_checks++; if (bus.wr_data !== 8'h00) $display("FAIL reset_wr_data got %h req 00", bus.wr_data); else n_pass++;
    for (int a = 0; a < 16; a++) begin
      loc_read(4'(a), d);
      n_checks++; if (d !== 8'h00) $display("FAIL reset_reg[%0d] got %h req 00", a, d); else n_pass++;
      m_regs[a] = 8'h00;
    end
    tick(1); rst = 1'b0; tick(10);
  endtask

  task automatic test_mode0_write();
    logic [7:0] rx, d;
    set_mode(0); clear_q();
    tx_buf[0] = 8'h03; tx_buf[1] = 8'hAA; tx_buf[2] = 8'h55;
    model_xfer(3);
    cs_low();
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL busy_during got %b req 1", bus.busy); else n_pass++;
    for (int k = 0; k < 3; k++) begin spi_bits(tx_buf[k], 8, rx); rx_buf[k] = rx; end
    cs_high();
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL busy_after got %b req 0", bus.busy); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (rx_buf[k] !== exp_rx[k]) $display("FAIL wr0_rx[%0d] got %h req %h", k, rx_buf[k], exp_rx[k]); else n_pass++;
    end
    loc_read(4'd3, d);
    n_checks++; if (d !== 8'hAA) $display("FAIL wr0_reg3 got %h req aa", d); else n_pass++;
    loc_read(4'd4, d);
    n_checks++; if (d !== 8'h55) $display("FAIL wr0_reg4 got %h req 55", d); else n_pass++;
    n_checks++; if (obs_q.size() !== 2) $display("FAIL wr0_nstrobe got %0d req 2", obs_q.size()); else n_pass++;
    for (int k = 0; k < 2 && k < obs_q.size(); k++) begin
      n_checks++; if (obs_q[k] !== exp_q[k]) $display("FAIL wr0_strobe[%0d] got %h req %h", k, obs_q[k], exp_q[k]); else n_pass++;
    end
  endtask

  task automatic test_read_modes();
    for (int m = 0; m < 4; m++) begin
      set_mode(m); clear_q();
      loc_write(4'd15, 8'hC3);
      loc_write(4'd0, 8'h3C);
      tx_buf[0] = 8'h8F; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
      model_xfer(3);
      run_xfer(3);
      for (int k = 0; k < 3; k++) begin
        n_checks++; if (rx_buf[k] !== exp_rx[k]) $display("FAIL rd_mode%0d_rx[%0d] got %h req %h", m, k, rx_buf[k], exp_rx[k]); else n_pass++;
      end
      n_checks++; if (obs_q.size() !== 0) $display("FAIL rd_mode%0d_nstrobe got %0d req 0", m, obs_q.size()); else n_pass++;
    end
  endtask

  task automatic test_reserved();
    logic [7:0] d;
    set_mode(1); clear_q();
    tx_buf[0] = 8'h13; tx_buf[1] = 8'h77;
    model_xfer(2);
    run_xfer(2);
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (rx_buf[k] !== 8'h00) $display("FAIL rsv_rx[%0d] got %h req 00", k, rx_buf[k]); else n_pass++;
    end
    n_checks++; if (obs_q.size() !== 0) $display("FAIL rsv_nstrobe got %0d req 0", obs_q.size()); else n_pass++;
    loc_read(4'd3, d);
    n_checks++; if (d !== m_regs[3]) $display("FAIL rsv_reg3 got %h req %h", d, m_regs[3]); else n_pass++;
  endtask

  task automatic test_partial();
    logic [7:0] rx, d;
    set_mode(0); clear_q();
    loc_write(4'd2, 8'h96);
    cs_low();
    spi_bits(8'h02, 8, rx);
    spi_bits(8'hFF, 5, rx);
    cs_high();
    n_checks++; if (obs_q.size() !== 0) $display("FAIL partial_nstrobe got %0d req 0", obs_q.size()); else n_pass++;
    loc_read(4'd2, d);
    n_checks++; if (d !== 8'h96) $display("FAIL partial_reg2 got %h req 96", d); else n_pass++;
    tx_buf[0] = 8'h02; tx_buf[1] = 8'h5A;
    model_xfer(2);
    run_xfer(2);
    loc_read(4'd2, d);
    n_checks++; if (d !== 8'h5A) $display("FAIL partial_next_reg2 got %h req 5a", d); else n_pass++;
    n_checks++; if (obs_q.size() !== 1) $display("FAIL partial_next_nstrobe got %0d req 1", obs_q.size()); else n_pass++;
    if (obs_q.size() > 0) begin
      n_checks++; if (obs_q[0] !== exp_q[0]) $display("FAIL partial_next_strobe got %h req %h", obs_q[0], exp_q[0]); else n_pass++;
    end
  endtask

  task automatic test_collision();
    logic [7:0] d;
    int cnt;
    set_mode(0); clear_q();
    tx_buf[0] = 8'h05; tx_buf[1] = 8'h11;
    model_xfer(2);
    cnt = 0;
    fork
      run_xfer(2);
      begin
        bus.loc_addr = 4'd5; bus.loc_wdata = 8'h77; bus.loc_we = 1'b1;
        while (cnt < 3000 && !bus.wr_pulse) begin tick(1); cnt++; end
        bus.loc_we = 1'b0;
      end
    join
    n_checks++; if (cnt >= 3000) $display("FAIL coll_timeout got %0d cycles req wr_pulse", cnt); else n_pass++;
    loc_read(4'd5, d);
    n_checks++; if (d !== 8'h11) $display("FAIL coll_reg5 got %h req 11", d); else n_pass++;
    n_checks++; if (obs_q.size() !== 1) $display("FAIL coll_nstrobe got %0d req 1", obs_q.size()); else n_pass++;
  endtask

  task automatic test_random();
    int n;
    logic [7:0] d;
    for (int it = 0; it < 24; it++) begin
      set_mode(int'($urandom_range(0, 3))); clear_q();
      loc_write(4'($urandom_range(0, 15)), 8'($urandom));
      n = 1 + int'($urandom_range(1, 4));
      tx_buf[0] = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) tx_buf[0][7] = 1'b1;
      if ($urandom_range(0, 5) == 0) tx_buf[0][6:4] = 3'($urandom_range(1, 7));
      for (int k = 1; k < n; k++) tx_buf[k] = 8'($urandom);
      model_xfer(n);
      run_xfer(n);
      for (int k = 0; k < n; k++) begin
        n_checks++; if (rx_buf[k] !== exp_rx[k]) $display("FAIL rnd%0d_rx[%0d] cmd %h got %h req %h", it, k, tx_buf[0], rx_buf[k], exp_rx[k]); else n_pass++;
      end
      n_checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL rnd%0d_nstrobe got %0d req %0d", it, obs_q.size(), exp_q.size()); else n_pass++;
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
        n_checks++; if (obs_q[k] !== exp_q[k]) $display("FAIL rnd%0d_strobe[%0d] got %h req %h", it, k, obs_q[k], exp_q[k]); else n_pass++;
      end
    end
    for (int a = 0; a < 16; a++) begin
      loc_read(4'(a), d);
      n_checks++; if (d !== m_regs[a]) $display("FAIL rnd_reg[%0d] got %h req %h", a, d, m_regs[a]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rx, d;
    set_mode(0); clear_q();
    loc_write(4'd0, 8'hFF);
    loc_write(4'd1, 8'hFF);
    cs_low();
    spi_bits(8'h80, 8, rx);
    spi_bits(8'h00, 4, rx);
    rst = 1'b1;
    tick(2);
    n_checks++; if (bus.MISO !== 1'b0) $display("FAIL rstmid_miso got %b req 0", bus.MISO); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL rstmid_busy got %b req 0", bus.busy); else n_pass++;
    for (int a = 0; a < 16; a++) begin
      loc_read(4'(a), d);
      n_checks++; if (d !== 8'h00) $display("FAIL rstmid_reg[%0d] got %h req 00", a, d); else n_pass++;
      m_regs[a] = 8'h00;
    end
    tick(1); rst = 1'b0; tick(2);
    clear_q();
    spi_bits(8'h00, 4, rx);
    spi_bits(8'hA5, 8, rx);
    n_checks++; if (rx !== 8'h00) $display("FAIL rstmid_ignored_rx got %h req 00", rx); else n_pass++;
    cs_high();
    n_checks++; if (obs_q.size() !== 0) $display("FAIL rstmid_nstrobe got %0d req 0", obs_q.size()); else n_pass++;
    tx_buf[0] = 8'h01; tx_buf[1] = 8'h42;
    model_xfer(2);
    run_xfer(2);
    tx_buf[0] = 8'h81; tx_buf[1] = 8'h00;
    model_xfer(2);
    run_xfer(2);
    n_checks++; if (rx_buf[1] !== exp_rx[1]) $display("FAIL rstmid_resume_rx got %h req %h", rx_buf[1], exp_rx[1]); else n_pass++;
    n_checks++; if (obs_q.size() !== 1) $display("FAIL rstmid_resume_nstrobe got %0d req 1", obs_q.size()); else n_pass++;
  endtask

  initial begin
    bus.CS = 1'b1; bus.SPI_SCLK = 1'b0; bus.MOSI = 1'b0;
    bus.CPOL = 1'b0; bus.CPHA = 1'b0;
    bus.loc_we = 1'b0; bus.loc_addr = 4'h0; bus.loc_wdata = 8'h00;
    test_reset();
    test_mode0_write();
    test_read_modes();
    test_reserved();
    test_partial();
    test_collision();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
